// File: rtl/cnt_sched_pkg.sv
// Shared types and defaults for the round-robin counter scheduler.
// Holds the FSM state encoding and the default requester count and counter width.
package cnt_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NREQ_DEF = 4;
  localparam int CW_DEF   = 4;

endpackage

// File: rtl/cnt_sched_rr_arbiter.sv
// Combinational round-robin picker: first asserted req at or above ptr wins, else wraps to lowest.
// Zero latency; win is all-zero when req is all-zero.
module rr_arbiter
  import cnt_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int PW   = $clog2(NREQ_DEF)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win
);

  logic [NREQ-1:0] hi;
  logic [NREQ-1:0] pool;

  always_comb begin
    hi = '0;
    for (int i = 0; i < NREQ; i++) begin
      hi[i] = req[i] && (PW'(i) >= ptr);
    end
  end

  // Requests at or above the pointer take precedence; otherwise the search wraps.
  assign pool = (|hi) ? hi : req;
  assign win  = pool & (~pool + NREQ'(1));

endmodule

// File: rtl/cnt_sched.sv
// Shared counter granted round-robin to NREQ requesters; runs tc+1 cycles then pulses done.
// Grant registered one cycle after the request is seen in IDLE; dropping req mid-run aborts it.
module cnt_sched
  import cnt_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int CW   = CW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*CW-1:0] tc,
  output logic [NREQ-1:0]    gnt,
  output logic [CW-1:0]      cnt,
  output logic               busy,
  output logic [NREQ-1:0]    done
);

  localparam int PW = $clog2(NREQ);

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   gnt_idx;
  logic [PW-1:0]   ptr_nxt;
  logic [NREQ-1:0] win;
  logic [CW-1:0]   tc_q;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req (req),
    .ptr (ptr),
    .win (win)
  );

  always_comb begin
    win_idx = '0;
    gnt_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) win_idx = PW'(i);
      if (gnt[i]) gnt_idx = PW'(i);
    end
  end

  assign ptr_nxt = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      gnt   <= '0;
      done  <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      ptr   <= '0;
      tc_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= '0;
          cnt  <= '0;
          if (|req) begin
            state <= RUN;
            gnt   <= win;
            tc_q  <= tc[int'(win_idx)*CW +: CW];
            busy  <= 1'b1;
          end else begin
            gnt  <= '0;
            busy <= 1'b0;
          end
        end
        RUN: begin
          // Withdrawn request ends the run silently; the pointer still moves past it.
          if ((req & gnt) == '0) begin
            state <= IDLE;
            gnt   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            ptr   <= ptr_nxt;
          end else if (cnt == tc_q) begin
            state <= DONE;
            done  <= gnt;
            gnt   <= '0;
            cnt   <= '0;
            ptr   <= ptr_nxt;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= '0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          done  <= '0;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnt_sched.sv
// Scoreboard bench for cnt_sched: directed runs push expected per-cycle output records,
// a negedge monitor pops and compares whenever the DUT shows activity.
module tb_cnt_sched;

  typedef struct packed {
    logic [3:0] gnt;
    logic [3:0] cnt;
    logic       busy;
    logic [3:0] done;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] tc;
  logic [3:0]  gnt;
  logic [3:0]  cnt;
  logic        busy;
  logic [3:0]  done;

  obs_t  exp_q[$];
  obs_t  mon_obs;
  obs_t  mon_exp;
  int    checks = 0;
  int    fails  = 0;
  string cur_test = "init";

  cnt_sched #(.NREQ(4), .CW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .tc    (tc),
    .gnt   (gnt),
    .cnt   (cnt),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Any cycle with activity on the outputs must match the next expected record.
  always @(negedge clk) begin
    mon_obs = {gnt, cnt, busy, done};
    if (busy === 1'b1 || (|gnt) === 1'b1 || (|done) === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL %s unexpected: gnt=%b cnt=%0d busy=%b done=%b, required no activity",
                 cur_test, gnt, cnt, busy, done);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_obs !== mon_exp) begin
          fails++;
          $display("FAIL %s: got gnt=%b cnt=%0d busy=%b done=%b, required gnt=%b cnt=%0d busy=%b done=%b",
                   cur_test, gnt, cnt, busy, done,
                   mon_exp.gnt, mon_exp.cnt, mon_exp.busy, mon_exp.done);
        end
      end
    end
  end

  task automatic push(input logic [3:0] g, input logic [3:0] c, input logic b, input logic [3:0] d);
    obs_t o;
    o = {g, c, b, d};
    exp_q.push_back(o);
  endtask

  // Grant g visible with cnt 0..last, then optionally one done cycle.
  task automatic exp_run(input logic [3:0] g, input int last, input bit fin);
    for (int k = 0; k <= last; k++) push(g, 4'(k), 1'b1, 4'b0000);
    if (fin) push(4'b0000, 4'd0, 1'b1, g);
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL %s drain: %0d records outstanding, required 0", cur_test, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    tick(2);
    reset = 1'b0;
    chk("rst_gnt",  {4'b0, gnt},  8'h00);
    chk("rst_cnt",  {4'b0, cnt},  8'h00);
    chk("rst_done", {4'b0, done}, 8'h00);
    chk("rst_busy", {7'b0, busy}, 8'h00);
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    tc    = 16'h0000;
    tick(1);
    cur_test = "reset";
    do_reset();
    tick(2);

    // Single request, tc=3: four RUN cycles then a done pulse.
    cur_test = "single";
    tc[3:0] = 4'd3;
    exp_run(4'b0001, 3, 1'b1);
    req = 4'b0001;
    drain();
    req = 4'b0000;
    tick(3);

    // All requesting with tc=0 from reset: grants rotate 0,1,2,3,0.
    cur_test = "contention";
    do_reset();
    tc = 16'h0000;
    exp_run(4'b0001, 0, 1'b1);
    exp_run(4'b0010, 0, 1'b1);
    exp_run(4'b0100, 0, 1'b1);
    exp_run(4'b1000, 0, 1'b1);
    exp_run(4'b0001, 0, 1'b1);
    req = 4'b1111;
    drain();
    req = 4'b0000;
    tick(3);

    // Abort at cnt=4: no done, pointer moves to 3.
    cur_test = "abort";
    tc[11:8] = 4'd9;
    exp_run(4'b0100, 4, 1'b0);
    req = 4'b0100;
    drain();
    req = 4'b0000;
    tick(3);
    cur_test = "after_abort";
    tc = 16'h0000;
    exp_run(4'b1000, 0, 1'b1);
    req = 4'b1011;
    drain();
    req = 4'b0000;
    tick(3);

    // Full-range terminal count: cnt climbs to 15 without wrapping.
    cur_test = "boundary";
    tc[7:4] = 4'd15;
    exp_run(4'b0010, 15, 1'b1);
    req = 4'b0010;
    drain();
    req = 4'b0000;
    tick(3);

    // tc and other requests changed mid-run must not disturb the run.
    cur_test = "stability";
    tc = 16'h0000;
    tc[3:0] = 4'd5;
    exp_run(4'b0001, 5, 1'b1);
    req = 4'b0001;
    tick(3);
    tc[3:0]   = 4'd1;
    tc[15:12] = 4'd7;
    req[3]    = 1'b1;
    drain();
    req = 4'b0000;
    tick(3);

    // Reset at cnt=2 clears everything, including the pointer.
    cur_test = "reset_mid";
    tc = 16'h0000;
    tc[11:8] = 4'd6;
    exp_run(4'b0100, 2, 1'b0);
    req = 4'b0100;
    drain();
    reset = 1'b1;
    req   = 4'b0000;
    @(negedge clk);
    #1;
    chk("midrst_gnt",  {4'b0, gnt},  8'h00);
    chk("midrst_cnt",  {4'b0, cnt},  8'h00);
    chk("midrst_done", {4'b0, done}, 8'h00);
    chk("midrst_busy", {7'b0, busy}, 8'h00);
    reset = 1'b0;
    cur_test = "post_reset";
    tc = 16'h0000;
    exp_run(4'b0001, 0, 1'b1);
    req = 4'b1111;
    drain();
    req = 4'b0000;
    tick(4);

    cur_test = "final";
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL leftover: %0d records outstanding, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
